// File: rtl/key_debounce.sv
// key_debounce: synchronize and debounce active-low keys into clean levels plus press/release pulses
module key_debounce #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [NUM_KEYS-1:0] sync1, sync2, s;
  assign s = ~sync2;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n_raw;
      sync2 <= sync1;
    end
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [CNT_W-1:0] cnt;
    logic lvl, prs, rel;
    assign key_level[k]   = lvl;
    assign key_press[k]   = prs;
    assign key_release[k] = rel;
    // any sample matching the committed level restarts the count from zero
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt <= '0;
        lvl <= 1'b0;
        prs <= 1'b0;
        rel <= 1'b0;
      end else begin
        prs <= 1'b0;
        rel <= 1'b0;
        if (s[k] == lvl) cnt <= '0;
        else if (cnt == LAST) begin
          cnt <= '0;
          lvl <= s[k];
          prs <= s[k];
          rel <= ~s[k];
        end else cnt <= cnt + CNT_W'(1);
      end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and random key bouncing against a sliding-window reference model
module tb_key_debounce;
  localparam int D = 4;
  logic clk, reset_n;
  logic [3:0] key_n_raw, key_level, key_press, key_release;
  logic [3:0] r1, r2, m_lvl, m_prs, m_rel;
  logic [D-1:0] hist [4];
  int checks, errors;

  key_debounce #(.NUM_KEYS(4), .DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk), .reset_n(reset_n), .key_n_raw(key_n_raw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    r1 = '1;
    r2 = '1;
    m_lvl = '0;
    m_prs = '0;
    m_rel = '0;
    for (int k = 0; k < 4; k++) hist[k] = '0;
  endtask

  // a key commits once its last D synchronized samples all disagree with its level
  task automatic tick(input logic [3:0] raw);
    logic [3:0] samp;
    key_n_raw = raw;
    @(posedge clk);
    samp = ~r2;
    m_prs = '0;
    m_rel = '0;
    for (int k = 0; k < 4; k++) begin
      hist[k] = {hist[k][D-2:0], samp[k]};
      if (hist[k] == {D{~m_lvl[k]}}) begin
        m_lvl[k] = samp[k];
        m_prs[k] = samp[k];
        m_rel[k] = ~samp[k];
      end
    end
    r2 = r1;
    r1 = raw;
    #1;
    chk("model", {key_level, key_press, key_release}, {m_lvl, m_prs, m_rel});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async", {key_level, key_press, key_release}, 12'h000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold", {key_level, key_press, key_release}, 12'h000);
    reset_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    key_n_raw = '1;
    reset_n = 1'b1;
    model_reset();
    #2;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick(4'b1111);
      chk("idle_zero", {key_level, key_press, key_release}, 12'h000);
    end
    for (int i = 0; i < 8; i++) begin
      tick(4'b1110);
      if (i == 4) chk("press_early", {8'h0, key_level}, 12'h000);
      if (i == 5) chk("press_edge5", {4'h0, key_level, key_press}, 12'h011);
      if (i == 6) chk("press_edge6", {4'h0, key_level, key_press}, 12'h010);
    end
    for (int i = 0; i < 3; i++) tick(4'b1100);
    tick(4'b1110);
    for (int i = 0; i < 8; i++) begin
      tick(4'b1100);
      if (i == 4) chk("bounce_hold", {8'h0, key_level}, 12'h001);
      if (i == 5) chk("bounce_commit", {4'h0, key_level, key_press}, 12'h032);
    end
    tick(4'b1000);
    tick(4'b1000);
    for (int i = 0; i < 8; i++) begin
      tick(4'b1100);
      chk("glitch", {4'h0, key_level[2], key_press[2], key_release[2]}, 12'h000);
    end
    for (int i = 0; i < 8; i++) begin
      tick(4'b1101);
      if (i == 5) chk("release_edge5", {key_level, key_press, key_release}, 12'h201);
      if (i == 6) chk("release_edge6", {key_level, key_press, key_release}, 12'h200);
    end
    for (int i = 0; i < 8; i++) tick(4'b1111);
    for (int i = 0; i < 8; i++) begin
      tick(4'b0110);
      if (i == 5) chk("simul_edge5", {4'h0, key_level, key_press}, 12'h099);
      if (i == 6) chk("simul_edge6", {4'h0, key_level, key_press}, 12'h090);
    end
    for (int i = 0; i < 8; i++) tick(4'b1111);
    for (int i = 0; i < 8; i++) tick(4'b1101);
    tick(4'b1100);
    tick(4'b1100);
    tick(4'b1100);
    #2;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick(4'b1111);
      chk("post_rst_zero", {key_level, key_press, key_release}, 12'h000);
    end
    tick(4'b1110);
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(4'b1110);
      if (i == 5) chk("held_over_rst", {4'h0, key_level, key_press}, 12'h011);
    end
    for (int n = 0; n < 80; n++) begin
      logic [3:0] raw;
      raw = 4'($urandom);
      repeat ($urandom_range(1, 7)) tick(raw);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
